// File: rtl/packet_splitter_if.sv
// Packet-in / flit-out handshake bundle for packet_splitter.
// The master side drives packets and flit_ready_in. The slave side is the splitter.
interface packet_splitter_if #(
  parameter int NODE_W = 3,
  parameter int FLIT_W = 31
);
  logic [67:0]       packet_in;
  logic [NODE_W-1:0] node_dest_in;
  logic              valid_in;
  logic              ready_out;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid_out;
  logic              flit_ready_in;

  modport master (
    output packet_in, node_dest_in, valid_in, flit_ready_in,
    input  ready_out, flit_out, flit_valid_out
  );

  modport slave (
    input  packet_in, node_dest_in, valid_in, flit_ready_in,
    output ready_out, flit_out, flit_valid_out
  );
endinterface

// File: rtl/packet_splitter.sv
// Source-side serializer: buffers 68-bit packets, tags them with a rolling ID,
// and emits each packet as four 17-bit-payload flits under valid/ready.
module packet_splitter #(
  parameter  int NODE_COUNT      = 8,
  parameter  int PACKET_ID_WIDTH = 5,
  parameter  int NODE_ID         = 0,
  parameter  int BUFFER_SIZE     = 4,
  localparam int NODE_W          = $clog2(NODE_COUNT),
  localparam int ID_W            = PACKET_ID_WIDTH,
  localparam int FLIT_W          = 1 + 2*NODE_W + ID_W + 17 + 2,
  localparam int CNT_W           = $clog2(BUFFER_SIZE) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  packet_splitter_if.slave    bus,
  output logic [ID_W-1:0]     packet_id_out,
  output logic [CNT_W-1:0]    fifo_count,
  output logic                busy
);

  localparam int AW      = $clog2(BUFFER_SIZE);
  localparam int ENTRY_W = 68 + NODE_W;

  typedef enum logic {IDLE, SEND} state_t;

  logic [ENTRY_W-1:0] mem [BUFFER_SIZE];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, empty, push, load;
  logic [67:0]        head_pkt;
  logic [NODE_W-1:0]  head_dest;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [67:0]       data_q, data_d;
  logic [NODE_W-1:0] dest_q, dest_d;
  logic [ID_W-1:0]   pid_q, pid_d, id_cnt_q, id_cnt_d;
  logic              fv_q, fv_d;
  logic [16:0]       chunk;

  assign full  = (count == CNT_W'(BUFFER_SIZE));
  assign empty = (count == '0);
  // No bypass when full: a pop in the same cycle does not open a slot early.
  assign push  = ce && bus.valid_in && !full;
  assign {head_pkt, head_dest} = mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.packet_in, bus.node_dest_in};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      if (push && !load)      count <= count + 1'b1;
      else if (load && !push) count <= count - 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    dest_d   = dest_q;
    pid_d    = pid_q;
    id_cnt_d = id_cnt_q;
    fv_d     = fv_q;
    load     = 1'b0;

    unique case (state_q)
      IDLE: if (ce && !empty) load = 1'b1;
      SEND: begin
        if (ce && bus.flit_ready_in) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            fv_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading from IDLE and back-to-back loading at the last flit share one path.
    if (load) begin
      state_d  = SEND;
      idx_d    = 2'd0;
      fv_d     = 1'b1;
      data_d   = head_pkt;
      dest_d   = head_dest;
      pid_d    = id_cnt_q;
      id_cnt_d = id_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      dest_q   <= '0;
      pid_q    <= '0;
      id_cnt_q <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      dest_q   <= dest_d;
      pid_q    <= pid_d;
      id_cnt_q <= id_cnt_d;
      fv_q     <= fv_d;
    end
  end

  // Flit k carries the k-th 17-bit slice counting from the packet MSB.
  always_comb begin
    unique case (idx_q)
      2'd0:    chunk = data_q[67:51];
      2'd1:    chunk = data_q[50:34];
      2'd2:    chunk = data_q[33:17];
      default: chunk = data_q[16:0];
    endcase
  end

  assign bus.flit_out       = fv_q ? {1'b1, dest_q, chunk, pid_q, NODE_W'(NODE_ID), idx_q}
                                   : '0;
  assign bus.flit_valid_out = fv_q;
  assign bus.ready_out      = !full;
  assign packet_id_out      = pid_q;
  assign fifo_count         = count;
  assign busy               = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_packet_splitter.sv
// Scoreboard bench for packet_splitter: stimulus queues expected flits, a
// negedge monitor pops and compares every flit the downstream accepts.
module tb_packet_splitter;
  localparam int NODE_W = 3;
  localparam int ID_W   = 5;
  localparam int FLIT_W = 31;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst, ce;
  always #5 clk = ~clk;

  packet_splitter_if #(.NODE_W(NODE_W), .FLIT_W(FLIT_W)) bus ();
  logic [ID_W-1:0]  packet_id_out;
  logic [CNT_W-1:0] fifo_count;
  logic             busy;

  packet_splitter #(
    .NODE_COUNT(8), .PACKET_ID_WIDTH(5), .NODE_ID(2), .BUFFER_SIZE(4)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus.slave),
    .packet_id_out(packet_id_out), .fifo_count(fifo_count), .busy(busy)
  );

  int              n_vec = 0;
  int              n_bad = 0;
  logic [FLIT_W-1:0] sb[$];
  int              cyc = 0;
  int              acc_cnt = 0;
  int              last_acc_cyc = 0;
  logic [67:0]     rx_pkt = '0;
  logic [ID_W-1:0] tb_id = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [NODE_W-1:0] d, input logic [16:0] data,
                                                input logic [ID_W-1:0] id, input logic [1:0] k);
    return {1'b1, d, data, id, 3'd2, k};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: inputs change only just after posedge, so negedge sees what the next edge accepts.
  always @(negedge clk) begin
    if (!rst && ce && bus.flit_valid_out && bus.flit_ready_in) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_flit: got %0h expected none", bus.flit_out);
      end else begin
        check("flit", bus.flit_out, sb.pop_front());
      end
      rx_pkt       = {rx_pkt[50:0], bus.flit_out[26:10]};
      acc_cnt      = acc_cnt + 1;
      last_acc_cyc = cyc;
    end else if (!bus.flit_valid_out) begin
      check("idle_flit_zero", bus.flit_out, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tb_id = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic push_pkt(input logic [67:0] p, input logic [NODE_W-1:0] d);
    int n = 0;
    while (!bus.ready_out && n < 200) begin
      tick();
      n++;
    end
    if (!bus.ready_out) begin
      n_vec++;
      n_bad++;
      $display("FAIL push_timeout: got ready_out=0 expected 1");
      return;
    end
    bus.packet_in    = p;
    bus.node_dest_in = d;
    bus.valid_in     = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back(mk_flit(d, p[67-17*k -: 17], tb_id, k[1:0]));
    tb_id++;
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.flit_valid_out && n < 20) begin
      tick();
      n++;
    end
    check("flit_valid_wait", bus.flit_valid_out, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    check("drain_done", (sb.size() == 0 && !busy), 1);
  endtask

  logic [67:0] p2, p6;
  int          base_acc, c0;

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    bus.valid_in      = 1'b0;
    bus.packet_in     = '0;
    bus.node_dest_in  = '0;
    bus.flit_ready_in = 1'b1;
    tick(2);
    check("rst_flit_valid", bus.flit_valid_out, 0);
    check("rst_flit_out", bus.flit_out, 0);
    check("rst_ready", bus.ready_out, 1);
    check("rst_count", fifo_count, 0);
    check("rst_pid", packet_id_out, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single packet, hand-computed flits (dest 5, NODE_ID 2, ID 0)
    bus.packet_in    = {17'h00001, 17'h00002, 17'h00003, 17'h00004};
    bus.node_dest_in = 3'd5;
    bus.valid_in     = 1'b1;
    sb.push_back(31'h68000408);
    sb.push_back(31'h68000809);
    sb.push_back(31'h68000C0A);
    sb.push_back(31'h6800100B);
    tb_id    = 5'd1;
    base_acc = acc_cnt;
    tick();
    bus.valid_in = 1'b0;
    check("t1_not_yet_valid", bus.flit_valid_out, 0);
    tick();
    check("t1_flit0_valid", bus.flit_valid_out, 1);
    check("t1_flit0", bus.flit_out, 31'h68000408);
    check("t1_pid", packet_id_out, 0);
    tick(4);
    check("t1_four_accepts", acc_cnt - base_acc, 4);
    check("t1_done_valid", bus.flit_valid_out, 0);
    wait_drain();

    // Backpressure on flit 1
    p2 = {17'h1AAAA, 17'h15555, 17'h0F0F0, 17'h00FF0};
    bus.flit_ready_in = 1'b0;
    push_pkt(p2, 3'd1);
    wait_valid();
    bus.flit_ready_in = 1'b1;
    tick();
    bus.flit_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_flit1_held", bus.flit_out, mk_flit(3'd1, 17'h15555, 5'd1, 2'd1));
      check("bp_valid_held", bus.flit_valid_out, 1);
      tick();
    end
    bus.flit_ready_in = 1'b1;
    wait_drain();

    // FIFO full: one packet in SEND plus four queued
    do_reset();
    bus.flit_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) push_pkt({4{17'(i * 17'h111 + 1)}}, 3'(i + 1));
    check("full_count", fifo_count, 4);
    check("full_ready", bus.ready_out, 0);
    bus.packet_in    = {4{17'h1FFFF}};
    bus.node_dest_in = 3'd7;
    bus.valid_in     = 1'b1;
    tick(2);
    bus.valid_in = 1'b0;
    check("full_sixth_rejected", fifo_count, 4);
    base_acc = acc_cnt;
    c0       = cyc;
    bus.flit_ready_in = 1'b1;
    wait_drain();
    check("full_20_flits", acc_cnt - base_acc, 20);
    check("full_no_bubbles", last_acc_cyc - c0, 19);

    // ID wrap over 33 packets
    do_reset();
    for (int i = 0; i < 33; i++)
      push_pkt({17'(i), 17'(i + 100), 17'(i * 3), 17'(~i)}, 3'(i));
    wait_drain();
    check("wrap_pid_33rd", packet_id_out, 0);

    // Reset after flit 1 is accepted
    bus.flit_ready_in = 1'b0;
    push_pkt({17'h12345, 17'h0ABCD, 17'h13579, 17'h02468}, 3'd6);
    wait_valid();
    bus.flit_ready_in = 1'b1;
    tick(2);
    bus.flit_ready_in = 1'b0;
    rst = 1'b1;
    sb.delete();
    tb_id = '0;
    tick();
    check("mid_rst_valid", bus.flit_valid_out, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ready", bus.ready_out, 1);
    check("mid_rst_pid", packet_id_out, 0);
    rst = 1'b0;
    bus.flit_ready_in = 1'b1;
    push_pkt({17'h00011, 17'h00022, 17'h00033, 17'h00044}, 3'd3);
    wait_drain();

    // ce gating during flit 2
    p6 = {17'h1C001, 17'h0E002, 17'h07003, 17'h03804};
    bus.flit_ready_in = 1'b0;
    push_pkt(p6, 3'd4);
    wait_valid();
    bus.flit_ready_in = 1'b1;
    tick(2);
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("ce_flit2_held", bus.flit_out, mk_flit(3'd4, 17'h07003, 5'd1, 2'd2));
      check("ce_valid_held", bus.flit_valid_out, 1);
    end
    ce = 1'b1;
    wait_drain();
    check("ce_reassembled", rx_pkt, p6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
